// File: rtl/seg7_bin2dec.sv
// Binary-to-decimal seven-segment formatter: double-dabble conversion, one bit per clock,
// followed by a registered update of eight digit patterns with optional leading-zero blanking.
module seg7_bin2dec #(
  parameter int unsigned WIDTH = 27
) (
  input  logic             iCLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] iVALUE,
  input  logic             iLOAD,
  input  logic             iLZB,
  output logic             oBUSY,
  output logic             oDONE,
  output logic             oOVF,
  output logic [6:0]       oSEG0,
  output logic [6:0]       oSEG1,
  output logic [6:0]       oSEG2,
  output logic [6:0]       oSEG3,
  output logic [6:0]       oSEG4,
  output logic [6:0]       oSEG5,
  output logic [6:0]       oSEG6,
  output logic [6:0]       oSEG7
);

  localparam logic [31:0] MaxDisplay = 32'd99_999_999;
  localparam logic [6:0]  SegDash    = 7'b0000001;
  localparam logic [6:0]  SegBlank   = 7'b0000000;

  typedef enum logic [1:0] {StIdle, StConv, StOut} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [31:0]      r_bcd, w_bcd_nxt;
  logic [4:0]       r_cnt, w_cnt_nxt;
  logic             r_lzb, w_lzb_nxt;
  logic             r_ovf_pend, w_ovf_pend_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_done, w_done_nxt;
  logic [7:0][6:0]  r_seg, w_seg_nxt;

  logic [31:0]      w_value_ext;
  logic [31:0]      w_bcd_adj;
  logic [7:0][6:0]  w_seg_fmt;
  logic             w_lead;
  logic [3:0]       w_nib;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'b1111110;
      4'd1:    seg_enc = 7'b0110000;
      4'd2:    seg_enc = 7'b1101101;
      4'd3:    seg_enc = 7'b1111001;
      4'd4:    seg_enc = 7'b0110011;
      4'd5:    seg_enc = 7'b1011011;
      4'd6:    seg_enc = 7'b1011111;
      4'd7:    seg_enc = 7'b1110000;
      4'd8:    seg_enc = 7'b1111111;
      4'd9:    seg_enc = 7'b1111011;
      default: seg_enc = SegBlank;
    endcase
  endfunction

  assign w_value_ext = 32'(iVALUE);

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 8; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Scan from the top digit down; digits stay "leading" until the first nonzero one.
  always_comb begin
    w_seg_fmt = '0;
    w_lead    = 1'b1;
    w_nib     = '0;
    for (int i = 7; i >= 0; i--) begin
      w_nib = r_bcd[4*i +: 4];
      if (w_nib != 4'd0) begin
        w_lead = 1'b0;
      end
      if (r_ovf_pend) begin
        w_seg_fmt[i] = SegDash;
      end else if (r_lzb && w_lead && (i != 0)) begin
        w_seg_fmt[i] = SegBlank;
      end else begin
        w_seg_fmt[i] = seg_enc(w_nib);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bcd_nxt      = r_bcd;
    w_cnt_nxt      = r_cnt;
    w_lzb_nxt      = r_lzb;
    w_ovf_pend_nxt = r_ovf_pend;
    w_ovf_nxt      = r_ovf;
    w_done_nxt     = 1'b0;
    w_seg_nxt      = r_seg;
    case (r_state)
      StIdle: begin
        if (iLOAD) begin
          w_shift_nxt    = iVALUE;
          w_bcd_nxt      = '0;
          w_cnt_nxt      = '0;
          w_lzb_nxt      = iLZB;
          w_ovf_pend_nxt = (w_value_ext > MaxDisplay);
          w_state_nxt    = StConv;
        end
      end
      StConv: begin
        w_bcd_nxt   = {w_bcd_adj[30:0], r_shift[WIDTH-1]};
        w_shift_nxt = r_shift << 1;
        w_cnt_nxt   = r_cnt + 5'd1;
        if (r_cnt == 5'(WIDTH - 1)) begin
          w_state_nxt = StOut;
        end
      end
      StOut: begin
        w_seg_nxt   = w_seg_fmt;
        w_ovf_nxt   = r_ovf_pend;
        w_done_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (nRST) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_lzb      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
      r_seg      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bcd      <= w_bcd_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lzb      <= w_lzb_nxt;
      r_ovf_pend <= w_ovf_pend_nxt;
      r_ovf      <= w_ovf_nxt;
      r_done     <= w_done_nxt;
      r_seg      <= w_seg_nxt;
    end
  end

  assign oBUSY = (r_state != StIdle);
  assign oDONE = r_done;
  assign oOVF  = r_ovf;
  assign oSEG0 = r_seg[0];
  assign oSEG1 = r_seg[1];
  assign oSEG2 = r_seg[2];
  assign oSEG3 = r_seg[3];
  assign oSEG4 = r_seg[4];
  assign oSEG5 = r_seg[5];
  assign oSEG6 = r_seg[6];
  assign oSEG7 = r_seg[7];

endmodule

// File: tb/tb_seg7_bin2dec.sv
// Directed bench for seg7_bin2dec: vector table of conversions plus hand-built sequences for
// ignored loads, reset abort and back-to-back conversions.
module tb_seg7_bin2dec;

  localparam int unsigned WIDTH = 27;
  localparam int unsigned LAT   = WIDTH + 1;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SD = 7'b0000001;
  localparam logic [6:0] SB = 7'b0000000;

  logic             iCLK = 1'b0;
  logic             nRST;
  logic [WIDTH-1:0] iVALUE;
  logic             iLOAD;
  logic             iLZB;
  logic             oBUSY, oDONE, oOVF;
  logic [6:0]       oSEG0, oSEG1, oSEG2, oSEG3, oSEG4, oSEG5, oSEG6, oSEG7;

  int n_checks = 0;
  int n_errors = 0;

  seg7_bin2dec #(.WIDTH(WIDTH)) dut (
    .iCLK  (iCLK),
    .nRST  (nRST),
    .iVALUE(iVALUE),
    .iLOAD (iLOAD),
    .iLZB  (iLZB),
    .oBUSY (oBUSY),
    .oDONE (oDONE),
    .oOVF  (oOVF),
    .oSEG0 (oSEG0),
    .oSEG1 (oSEG1),
    .oSEG2 (oSEG2),
    .oSEG3 (oSEG3),
    .oSEG4 (oSEG4),
    .oSEG5 (oSEG5),
    .oSEG6 (oSEG6),
    .oSEG7 (oSEG7)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] value;
    logic        lzb;
    logic [55:0] segs;  // {oSEG7 .. oSEG0}
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [55:0] segs_now();
    return {oSEG7, oSEG6, oSEG5, oSEG4, oSEG3, oSEG2, oSEG1, oSEG0};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge following oDONE.
  task automatic do_load(input logic [31:0] value, input logic lzb,
                         input logic [55:0] exp_segs, input logic exp_ovf, input string name);
    logic [55:0] prev;
    int          lat;
    prev   = segs_now();
    iVALUE = value[WIDTH-1:0];
    iLZB   = lzb;
    iLOAD  = 1'b1;
    @(posedge iCLK);
    #1;
    iLOAD  = 1'b0;
    iVALUE = ~value[WIDTH-1:0];
    iLZB   = ~lzb;
    check({name, " busy after load"}, 64'(oBUSY), 64'd1);
    lat = 0;
    while (lat < 60) begin
      @(posedge iCLK);
      #1;
      lat++;
      if (lat == 10) check({name, " hold mid-conv"}, 64'(segs_now()), 64'(prev));
      if (oDONE) break;
    end
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " segs"}, 64'(segs_now()), 64'(exp_segs));
    check({name, " ovf"}, 64'(oOVF), 64'(exp_ovf));
    check({name, " busy at done"}, 64'(oBUSY), 64'd0);
    @(posedge iCLK);
    #1;
    check({name, " done pulse ends"}, 64'(oDONE), 64'd0);
  endtask

  initial begin
    int seen_done;
    int lat;
    logic [55:0] exp_bb;

    vecs[0] = '{32'd12_345_678,  1'b0, {S1, S2, S3, S4, S5, S6, S7, S8}, 1'b0};
    vecs[1] = '{32'd0,           1'b1, {SB, SB, SB, SB, SB, SB, SB, S0}, 1'b0};
    vecs[2] = '{32'd305,         1'b1, {SB, SB, SB, SB, SB, S3, S0, S5}, 1'b0};
    vecs[3] = '{32'd99_999_999,  1'b0, {S9, S9, S9, S9, S9, S9, S9, S9}, 1'b0};
    vecs[4] = '{32'd100_000_000, 1'b0, {SD, SD, SD, SD, SD, SD, SD, SD}, 1'b1};
    vecs[5] = '{32'd0,           1'b0, {S0, S0, S0, S0, S0, S0, S0, S0}, 1'b0};
    vecs[6] = '{32'd134_217_727, 1'b1, {SD, SD, SD, SD, SD, SD, SD, SD}, 1'b1};
    vecs[7] = '{32'd10_000_000,  1'b1, {S1, S0, S0, S0, S0, S0, S0, S0}, 1'b0};
    vecs[8] = '{32'd7,           1'b1, {SB, SB, SB, SB, SB, SB, SB, S7}, 1'b0};
    vecs[9] = '{32'd90_600_040,  1'b1, {S9, S0, S6, S0, S0, S0, S4, S0}, 1'b0};

    // Reset with a load request pending: reset must win.
    nRST   = 1'b1;
    iLOAD  = 1'b1;
    iVALUE = 27'd5;
    iLZB   = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    check("reset busy", 64'(oBUSY), 64'd0);
    check("reset done", 64'(oDONE), 64'd0);
    check("reset ovf", 64'(oOVF), 64'd0);
    check("reset segs", 64'(segs_now()), 64'd0);
    nRST  = 1'b0;
    iLOAD = 1'b0;
    @(posedge iCLK);
    #1;
    check("idle after reset", 64'(oBUSY), 64'd0);

    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].value, vecs[i].lzb, vecs[i].segs, vecs[i].ovf, $sformatf("vec%0d", i));
    end

    // Load 42, then strobes at T+5 and T+28 must be ignored.
    iVALUE = 27'd42;
    iLZB   = 1'b0;
    iLOAD  = 1'b1;
    @(posedge iCLK);
    #1;
    iLOAD = 1'b0;
    seen_done = 0;
    for (int e = 1; e <= 28; e++) begin
      if (e == 5 || e == 28) begin
        iLOAD  = 1'b1;
        iVALUE = 27'd77;
      end
      @(posedge iCLK);
      #1;
      iLOAD = 1'b0;
      if (oDONE) seen_done++;
    end
    check("ign done at T+28", 64'(oDONE), 64'd1);
    check("ign single done", 64'(seen_done), 64'd1);
    check("ign segs 42", 64'(segs_now()), 64'({S0, S0, S0, S0, S0, S0, S4, S2}));
    check("ign busy T+28", 64'(oBUSY), 64'd0);
    @(posedge iCLK);
    #1;
    check("ign busy T+29", 64'(oBUSY), 64'd0);
    check("ign done T+29", 64'(oDONE), 64'd0);

    // Reset at T+10 of a conversion aborts it.
    iVALUE = 27'd55_555_555;
    iLZB   = 1'b0;
    iLOAD  = 1'b1;
    @(posedge iCLK);
    #1;
    iLOAD = 1'b0;
    repeat (9) @(posedge iCLK);
    #1;
    nRST = 1'b1;
    @(posedge iCLK);
    #1;
    nRST = 1'b0;
    check("abort busy", 64'(oBUSY), 64'd0);
    check("abort done", 64'(oDONE), 64'd0);
    check("abort segs blank", 64'(segs_now()), 64'd0);
    seen_done = 0;
    repeat (30) begin
      @(posedge iCLK);
      #1;
      if (oDONE || oBUSY) seen_done++;
    end
    check("abort no activity", 64'(seen_done), 64'd0);
    do_load(32'd7, 1'b0, {S0, S0, S0, S0, S0, S0, S0, S7}, 1'b0, "post-abort 7");

    // iLOAD held high: back-to-back conversions of 1, 2, 3.
    iVALUE = 27'd1;
    iLZB   = 1'b1;
    iLOAD  = 1'b1;
    @(posedge iCLK);
    #1;
    for (int v = 1; v <= 3; v++) begin
      lat = 0;
      while (lat < 60) begin
        @(posedge iCLK);
        #1;
        lat++;
        if (oDONE) break;
      end
      check($sformatf("b2b period %0d", v), 64'(lat), (v == 1) ? 64'(LAT) : 64'(WIDTH + 2));
      case (v)
        1:       exp_bb = {SB, SB, SB, SB, SB, SB, SB, S1};
        2:       exp_bb = {SB, SB, SB, SB, SB, SB, SB, S2};
        default: exp_bb = {SB, SB, SB, SB, SB, SB, SB, S3};
      endcase
      check($sformatf("b2b segs %0d", v), 64'(segs_now()), 64'(exp_bb));
      iVALUE = 27'(v + 1);
      if (v == 3) iLOAD = 1'b0;
    end
    @(posedge iCLK);
    #1;
    check("b2b stops", 64'(oBUSY), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_bin2dec.md
# seg7_bin2dec

Sequential binary-to-decimal display formatter for the 8-digit seven-segment scan driver. Accepts a binary value on a load strobe, converts it to 8 BCD digits by iterative shift-add-3 (double dabble), then encodes each digit into a 7-bit segment pattern. Its eight registered pattern outputs feed the scan driver's per-digit segment inputs (digit 0 = rightmost) and hold steady between conversions.

## Interface
- WIDTH, 27, binary input width; legal 1..27, since 27 bits covers 99,999,999.
- iCLK  in  1  system clock; every register updates on its rising edge.
- nRST  in  1  reset. One clock; reset is synchronous and active-high.
- iVALUE  in  WIDTH  unsigned binary value to display.
- iLOAD  in  1  start strobe; sampled only in IDLE.
- iLZB  in  1  leading-zero blanking enable; captured with iVALUE.
- oBUSY  out  1  high while a conversion is in progress (CONV or OUT).
- oDONE  out  1  one-cycle pulse on the edge the patterns update.
- oOVF  out  1  high when the last loaded value exceeded 99,999,999; updates with the patterns.
- oSEG0..oSEG7  out  7 each  segment patterns, digit 0 = least significant.
  - Bit 6..0 = a,b,c,d,e,f,g.
  - 1 = segment lit.

## Operation
- Segment encoding (a..g):
  - 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011
  - 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011
  - Dash 0000001; blank 0000000.
- State machine: IDLE, CONV, OUT.
- IDLE:
  - iLOAD=1 -> capture iVALUE into shift register; clear the 32-bit BCD register; clear bit counter.
  - Capture iLZB.
  - Latch overflow flag = (iVALUE > 99,999,999). Only reachable with WIDTH=27.
  - Go to CONV.
- CONV, one bit per cycle:
  - For each BCD nibble >= 5, add 3.
  - Then shift {BCD, shift reg} left by 1, MSB of the binary entering BCD bit 0.
  - Counter increments; when the counter reaches WIDTH-1, go to OUT.
- OUT, single cycle:
  - Register all eight patterns; assert oDONE; update oOVF; go to IDLE.
  - Overflow set: all eight digits = dash.
  - Otherwise, blanking on: every digit above the most significant nonzero digit = blank. Digit 0 is never blanked (value 0 shows a single "0").
  - Otherwise, blanking off: all digits show their value, including leading zeros.
- iLOAD in CONV or OUT is ignored, not queued.
- iVALUE and iLZB are not observed after the load edge.
- Width rule: BCD register is 32 bits. Nibble adjust is applied to all 8 nibbles each cycle. For legal values, no nibble exceeds 9 after the final shift.

## Timing
- Reset values, applied at the first rising edge with nRST=1:
  - State IDLE; oBUSY 0, oDONE 0, oOVF 0.
  - All oSEGn = 0000000 (blank).
  - Shift, BCD and counter registers cleared.
- Reset has priority over every other action. Reset during CONV or OUT aborts the conversion: no oDONE, outputs blank.
- Load accepted at edge T:
  - oBUSY=1 from edge T.
  - CONV occupies edges T+1..T+WIDTH.
  - At edge T+WIDTH+1 (OUT) the patterns, oOVF and oDONE=1 update, and oBUSY returns to 0.
  - oDONE drops at edge T+WIDTH+2.
- Latency: WIDTH+1 cycles from load edge to pattern update (28 for default).
- Earliest next accepted load: edge T+WIDTH+2.
- iLOAD held high continuously: conversions repeat back to back, every WIDTH+2 cycles.
- Patterns hold their previous values during a conversion; they never show intermediate values.

## Test plan
- Reset, then load 12,345,678 with iLZB=0 -> at edge T+28:
  - oSEG7..0 = 1 2 3 4 5 6 7 8 patterns (e.g. oSEG0 = 1111111, oSEG7 = 0110000).
  - oDONE single pulse; oOVF=0.
- Load 0 with iLZB=1 -> oSEG0 = 1111110 and oSEG7..1 = 0000000. Then load 305 with iLZB=1:
  - oSEG2/1/0 = 3/0/5 patterns (oSEG1 = 1111110).
  - oSEG7..3 blank.
- Boundary values:
  - Load 99,999,999 -> all digits 1111011, oOVF=0.
  - Load 100,000,000 -> all digits 0000001, oOVF=1.
  - Load 0 with iLZB=0 -> eight "0" patterns, oOVF=0.
- Load 42, then pulse iLOAD with 77 at edges T+5 and T+28 (still busy) -> both ignored:
  - Result shows 42.
  - oBUSY low at T+28 and high again only after a load at edge ≥ T+29.
- Load 55,555,555; assert nRST at edge T+10 for one cycle -> no oDONE, all patterns blank, oBUSY=0. A new load of 7 then completes in 28 cycles showing 7.
- Hold iLOAD=1 with iVALUE stepping 1,2,3 each conversion -> oDONE every 29 cycles, with patterns tracking each captured value.
